lsu_mem_ctrl: RTL and testbench

Load/store unit between the CPU datapath and a multi-cycle, word-wide data memory. It turns the CPU's per-instruction memory request into a held request/acknowledge transaction: byte enables and lane-replicated write data for stores, lane extraction and sign/zero extension for loads. While a transaction is in flight it holds `stall` high, which the CPU ANDs into `PC_en` to freeze the instruction. Misaligned accesses, illegal `funct3` codes and memory timeouts are reported through a one-cycle `err` pulse.

---
 rtl/lsu_mem_ctrl_if.sv | 34 +++
 rtl/lsu_mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// Load/store unit bundle: CPU request side and word-wide memory side.
// slave is the LSU view, master is the CPU+memory view.
interface lsu_mem_ctrl_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;

  modport slave (
    input  req, we, funct3, addr, wdata,
    input  m_rdata, m_ack,
    output stall, rdata, done, err,
    output m_req, m_we, m_addr, m_be, m_wdata
  );

  modport master (
    output req, we, funct3, addr, wdata,
    output m_rdata, m_ack,
    input  stall, rdata, done, err,
    input  m_req, m_we, m_addr, m_be, m_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: CPU access -> held req/ack memory transaction,
// with lane steering, load extension and error reporting.
module lsu_mem_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input logic           clk,
  input logic           rst,
  lsu_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, DONE, ERR
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_lane;
  logic        r_m_req;
  logic        r_m_we;
  logic [31:0] r_m_addr;
  logic [3:0]  r_m_be;
  logic [31:0] r_m_wdata;
  logic [31:0] r_rdata;
  logic        r_done;
  logic        r_err;

  logic [1:0]  w_lane;
  logic        w_legal;
  logic        w_mis;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [15:0] w_sh;
  logic [31:0] w_ld;

  assign w_lane = bus.addr[1:0];

  assign w_legal =
    (!bus.funct3[2] && bus.funct3[1:0] != 2'b11) ||
    (!bus.we && bus.funct3[2] && !bus.funct3[1]);

  assign w_mis =
    (bus.funct3[1:0] == 2'b01 && bus.addr[0]) ||
    (bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.wdata;
    if (bus.we) begin
      unique case (1'b1)
        (bus.funct3[1:0] == 2'b00): begin
          w_be    = 4'b0001 << w_lane;
          w_wdata = {4{bus.wdata[7:0]}};
        end
        (bus.funct3[1:0] == 2'b01): begin
          w_be    = 4'b0011 << w_lane;
          w_wdata = {2{bus.wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Low 16 bits of the read word after shifting the addressed lane down
  assign w_sh = 16'(bus.m_rdata >> {r_lane, 3'b000});

  always_comb begin
    w_ld = bus.m_rdata;
    unique case (1'b1)
      (r_f3 == 3'b000): w_ld = {{24{w_sh[7]}}, w_sh[7:0]};
      (r_f3 == 3'b001): w_ld = {{16{w_sh[15]}}, w_sh};
      (r_f3 == 3'b100): w_ld = {24'h0, w_sh[7:0]};
      (r_f3 == 3'b101): w_ld = {16'h0, w_sh};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_f3      <= '0;
      r_lane    <= '0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_be    <= '0;
      r_m_wdata <= '0;
      r_rdata   <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.req) begin
            if (!w_legal || w_mis) begin
              r_err   <= 1'b1;
              r_rdata <= '0;
              r_state <= ERR;
            end else begin
              r_we      <= bus.we;
              r_f3      <= bus.funct3;
              r_lane    <= w_lane;
              r_m_req   <= 1'b1;
              r_m_we    <= bus.we;
              r_m_addr  <= {bus.addr[31:2], 2'b00};
              r_m_be    <= w_be;
              r_m_wdata <= w_wdata;
              r_cnt     <= '0;
              r_state   <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (bus.m_ack) begin
            if (!r_we) r_rdata <= w_ld;
            r_m_req <= 1'b0;
            r_m_we  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_cnt == 8'(MAX_WAIT)) begin
            r_m_req <= 1'b0;
            r_m_we  <= 1'b0;
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_state <= ERR;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: r_state <= IDLE;
        ERR:  r_state <= IDLE;
      endcase
    end
  end

  assign bus.stall   = bus.req &&
                       (r_state == IDLE || r_state == ACCESS);
  assign bus.rdata   = r_rdata;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.m_req   = r_m_req;
  assign bus.m_we    = r_m_we;
  assign bus.m_addr  = r_m_addr;
  assign bus.m_be    = r_m_be;
  assign bus.m_wdata = r_m_wdata;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: CPU driver plus memory responder,
// done/err pulses checked against a queue of expected results.
module tb_lsu_mem_ctrl;

  localparam int MW = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(.MAX_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        is_err;
    logic        is_ld;
    logic [31:0] rd;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && (bus.done === 1'b1 || bus.err === 1'b1)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", {30'b0, bus.done, bus.err}, 32'b0);
      end else begin
        e = sbq.pop_front();
        chk("kind_err", 32'(bus.err), 32'(e.is_err));
        chk("kind_done", 32'(bus.done), 32'(!e.is_err));
        if (e.is_err || e.is_ld) chk("rdata", bus.rdata, e.rd);
      end
    end
  end

  // dly = ACCESS cycles before the ack cycle; negative means never ack
  task automatic op(string tag, logic w, logic [2:0] f3,
                    logic [31:0] a, logic [31:0] wd,
                    logic [31:0] mrd, int dly, logic bad);
    exp_t        e;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] rd;
    logic [31:0] sh;
    logic [1:0]  ln;
    int          ns;
    int          nm;
    int          cyc;
    bit          fin;
    ln  = a[1:0];
    be  = 4'b1111;
    mwd = wd;
    if (w && f3[1:0] == 2'b00) begin
      be  = 4'b0001 << ln;
      mwd = {4{wd[7:0]}};
    end else if (w && f3[1:0] == 2'b01) begin
      be  = 4'b0011 << ln;
      mwd = {2{wd[15:0]}};
    end
    sh = mrd >> (8 * ln);
    case (f3)
      3'b000:  rd = {{24{sh[7]}}, sh[7:0]};
      3'b001:  rd = {{16{sh[15]}}, sh[15:0]};
      3'b100:  rd = {24'h0, sh[7:0]};
      3'b101:  rd = {16'h0, sh[15:0]};
      default: rd = mrd;
    endcase
    e.is_err = bad || (dly < 0);
    e.is_ld  = !w;
    e.rd     = e.is_err ? 32'h0 : rd;

    @(negedge clk);
    bus.req     = 1'b1;
    bus.we      = w;
    bus.funct3  = f3;
    bus.addr    = a;
    bus.wdata   = wd;
    bus.m_rdata = mrd;
    bus.m_ack   = 1'b0;
    sbq.push_back(e);
    #1;
    ns  = bus.stall ? 1 : 0;
    nm  = 0;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.done || bus.err) begin
        fin = 1'b1;
      end else begin
        if (bus.stall) ns++;
        if (bus.m_req) begin
          nm++;
          chk({tag, "_m_addr"}, bus.m_addr, {a[31:2], 2'b00});
          chk({tag, "_m_we"}, 32'(bus.m_we), 32'(w));
          chk({tag, "_m_be"}, 32'(bus.m_be), 32'(be));
          if (w) chk({tag, "_m_wdata"}, bus.m_wdata, mwd);
          bus.m_ack = (nm - 1 == dly);
        end else begin
          bus.m_ack = 1'b0;
        end
      end
    end
    chk({tag, "_finished"}, 32'(fin), 32'd1);
    chk({tag, "_stall_low_end"}, 32'(bus.stall), 32'd0);
    if (bad) begin
      chk({tag, "_stall_cyc"}, 32'(ns), 32'd1);
      chk({tag, "_mreq_cyc"}, 32'(nm), 32'd0);
    end else if (dly < 0) begin
      chk({tag, "_stall_cyc"}, 32'(ns), 32'(MW + 2));
      chk({tag, "_mreq_cyc"}, 32'(nm), 32'(MW + 1));
    end else begin
      chk({tag, "_stall_cyc"}, 32'(ns), 32'(dly + 2));
      chk({tag, "_mreq_cyc"}, 32'(nm), 32'(dly + 1));
    end
    bus.m_ack = 1'b0;
    bus.req   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b0;
    bus.req     = 1'b1;
    bus.we      = 1'b0;
    bus.funct3  = 3'b000;
    bus.addr    = '0;
    bus.wdata   = '0;
    bus.m_rdata = '0;
    bus.m_ack   = 1'b0;
    #12;
    chk("rst_stall_follows_req", 32'(bus.stall), 32'd1);
    chk("rst_m_req", 32'(bus.m_req), 32'd0);
    chk("rst_m_addr", bus.m_addr, 32'd0);
    chk("rst_m_be", 32'(bus.m_be), 32'd0);
    chk("rst_m_wdata", bus.m_wdata, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_done_err", {30'b0, bus.done, bus.err}, 32'd0);
    bus.req = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    op("lw",   1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    op("lb",   1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 1'b0);
    op("lbu",  1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 1, 1'b0);
    op("sh",   1'b1, 3'b001, 32'h22, 32'h1234ABCD, 32'h0, 3, 1'b0);
    op("lw_mis", 1'b0, 3'b010, 32'h101, 32'h0, 32'h5555AAAA, 0, 1'b1);
    op("ill_ld", 1'b0, 3'b011, 32'h200, 32'h0, 32'h5555AAAA, 0, 1'b1);
    op("tmo",  1'b0, 3'b010, 32'h300, 32'h0, 32'h11111111, -1, 1'b0);
    op("lw2",  1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 0, 1'b0);
    op("sb",   1'b1, 3'b000, 32'h41, 32'h000000EF, 32'h0, 0, 1'b0);
    op("lh",   1'b0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 2, 1'b0);
    op("lhu",  1'b0, 3'b101, 32'h102, 32'h0, 32'h80017FFF, 0, 1'b0);
    op("sw",   1'b1, 3'b010, 32'h8, 32'h89ABCDEF, 32'h0, 2, 1'b0);
    op("ill_st", 1'b1, 3'b100, 32'h10, 32'h1, 32'h0, 0, 1'b1);
    op("sh_mis", 1'b1, 3'b001, 32'h23, 32'h1, 32'h0, 0, 1'b1);

    @(negedge clk);
    bus.m_ack = 1'b1;
    @(negedge clk);
    bus.m_ack = 1'b0;
    chk("stray_ack_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("stray_ack_done2", 32'(bus.done), 32'd0);

    bus.req    = 1'b1;
    bus.we     = 1'b0;
    bus.funct3 = 3'b010;
    bus.addr   = 32'h300;
    @(negedge clk);
    chk("pre_rst_m_req", 32'(bus.m_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_m_req", 32'(bus.m_req), 32'd0);
    chk("mid_rst_m_we_addr", {31'b0, bus.m_we} | bus.m_addr, 32'd0);
    chk("mid_rst_done_err", {30'b0, bus.done, bus.err}, 32'd0);
    bus.req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    op("lw_post_rst", 1'b0, 3'b010, 32'h400, 32'h0, 32'h0BADC0DE, 1, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
